// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: butterfly address generator for one NTT stage.
// Latches stage geometry on a new-stage trigger and walks every butterfly.
// Ports: clk, i_reset (async, active-high); i_point_configuration (N=64<<cfg),
//   i_working, i_new_stage_trigger, geometry (i_calcs_per_group, i_stride,
//   i_stride_index_offset, i_group_offset); i_ready / o_valid handshake;
//   o_addr_a, o_addr_b, o_twiddle_idx, o_last, o_stage_done, o_busy.
module ntt_addr_gen #(
   parameter int ADDR_W = 13,
   parameter int TW_W   = 12
) (
   input  logic              clk,
   input  logic              i_reset,
   input  logic [2:0]        i_point_configuration,
   input  logic              i_working,
   input  logic              i_new_stage_trigger,
   input  logic [9:0]        i_calcs_per_group,
   input  logic [7:0]        i_stride_index_offset,
   input  logic [9:0]        i_stride,
   input  logic [7:0]        i_group_offset,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr_a,
   output logic [ADDR_W-1:0] o_addr_b,
   output logic [TW_W-1:0]   o_twiddle_idx,
   output logic              o_last,
   output logic              o_stage_done,
   output logic              o_busy
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [11:0]       tlast_q, tlast_d;
   logic [11:0]       cnt_q, cnt_d;
   logic [9:0]        cm1_q, cm1_d;
   logic [9:0]        k_q, k_d;
   logic [9:0]        stride_q, stride_d;
   logic [7:0]        sio_q, sio_d;
   logic [7:0]        goff_q, goff_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [ADDR_W-1:0] b_q, b_d;
   logic [TW_W-1:0]   tw_q, tw_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic              start;
   logic [12:0]       total;

   assign start = i_new_stage_trigger && i_working;
   assign total = 13'd32 << i_point_configuration;

   always_comb begin
      state_d  = state_q;
      tlast_d  = tlast_q;
      cnt_d    = cnt_q;
      cm1_d    = cm1_q;
      k_d      = k_q;
      stride_d = stride_q;
      sio_d    = sio_q;
      goff_d   = goff_q;
      base_d   = base_q;
      tw_d     = tw_q;
      done_d   = 1'b0;
      // A trigger always wins, even over the final handshake.
      if (start) begin
         state_d  = RUN;
         tlast_d  = 12'(total - 13'd1);
         cm1_d    = (i_calcs_per_group == '0) ? '0
                                              : i_calcs_per_group - 10'd1;
         stride_d = i_stride;
         sio_d    = i_stride_index_offset;
         goff_d   = i_group_offset;
         cnt_d    = '0;
         k_d      = '0;
         base_d   = '0;
         tw_d     = '0;
      end else if (state_q == RUN && !i_working) begin
         state_d = IDLE;
      end else if (state_q == RUN && i_ready) begin
         if (cnt_q == tlast_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + 12'd1;
            if (k_q == cm1_q) begin
               k_d    = '0;
               tw_d   = '0;
               base_d = base_q + ADDR_W'(stride_q) + ADDR_W'(goff_q);
            end else begin
               k_d  = k_q + 10'd1;
               tw_d = tw_q + TW_W'(sio_q);
            end
         end
      end
      // Output registers load the pair for the next-state counters.
      a_d    = base_d + ADDR_W'(k_d);
      b_d    = a_d + ADDR_W'(stride_d);
      last_d = (state_d == RUN) && (cnt_d == tlast_d);
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= IDLE;
         tlast_q  <= '0;
         cnt_q    <= '0;
         cm1_q    <= '0;
         k_q      <= '0;
         stride_q <= '0;
         sio_q    <= '0;
         goff_q   <= '0;
         base_q   <= '0;
         tw_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tlast_q  <= tlast_d;
         cnt_q    <= cnt_d;
         cm1_q    <= cm1_d;
         k_q      <= k_d;
         stride_q <= stride_d;
         sio_q    <= sio_d;
         goff_q   <= goff_d;
         base_q   <= base_d;
         tw_q     <= tw_d;
         a_q      <= a_d;
         b_q      <= b_d;
         last_q   <= last_d;
         done_q   <= done_d;
      end
   end

   assign o_valid       = (state_q == RUN);
   assign o_busy        = (state_q == RUN);
   assign o_addr_a      = a_q;
   assign o_addr_b      = b_q;
   assign o_twiddle_idx = tw_q;
   assign o_last        = last_q;
   assign o_stage_done  = done_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// tb_ntt_addr_gen: scoreboard bench for ntt_addr_gen.
// Expected pairs are queued at each trigger and popped on every handshake.
module tb_ntt_addr_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  cfg;
   logic        working;
   logic        trg;
   logic [9:0]  calcs;
   logic [7:0]  sio;
   logic [9:0]  stride;
   logic [7:0]  goff;
   logic        ready;
   logic        valid;
   logic [12:0] addr_a;
   logic [12:0] addr_b;
   logic [11:0] tw;
   logic        last;
   logic        done;
   logic        busy;

   typedef struct packed {
      logic [12:0] a;
      logic [12:0] b;
      logic [11:0] tw;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc_n = 0;
   int          t0 = 0;
   int          done_cnt = 0;
   bit          bp = 0;
   int          bp_idx = 0;
   bit          stalled = 0;
   logic [12:0] pa, pb;
   logic [11:0] ptw;

   ntt_addr_gen dut (
      .clk                   (clk),
      .i_reset               (rst),
      .i_point_configuration (cfg),
      .i_working             (working),
      .i_new_stage_trigger   (trg),
      .i_calcs_per_group     (calcs),
      .i_stride_index_offset (sio),
      .i_stride              (stride),
      .i_group_offset        (goff),
      .i_ready               (ready),
      .o_valid               (valid),
      .o_addr_a              (addr_a),
      .o_addr_b              (addr_b),
      .o_twiddle_idx         (tw),
      .o_last                (last),
      .o_stage_done          (done),
      .o_busy                (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;
   always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic gen(int c, int cl, int st, int go, int si);
      int t = 32 << c;
      int cc = (cl == 0) ? 1 : cl;
      int k = 0;
      int base = 0;
      int w = 0;
      exp_t e;
      for (int i = 0; i < t; i++) begin
         e.a    = 13'(base + k);
         e.b    = 13'(base + k + st);
         e.tw   = 12'(w);
         e.last = (i == t - 1);
         sb.push_back(e);
         if (k == cc - 1) begin
            k = 0;
            w = 0;
            base = base + st + go;
         end else begin
            k++;
            w = w + si;
         end
      end
   endtask

   task automatic mon();
      exp_t e;
      @(negedge clk);
      if (stalled && valid) begin
         check("stall_a", addr_a, pa);
         check("stall_b", addr_b, pb);
         check("stall_tw", tw, ptw);
      end
      stalled = valid && !ready;
      pa = addr_a;
      pb = addr_b;
      ptw = tw;
      if (valid && ready) begin
         if (sb.size() == 0) begin
            check("extra_pair", 1, 0);
         end else begin
            e = sb.pop_front();
            check("addr_a", addr_a, e.a);
            check("addr_b", addr_b, e.b);
            check("twiddle", tw, e.tw);
            check("last", last, e.last);
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      if (bp) begin
         ready = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
         bp_idx++;
      end
   endtask

   task automatic trig(int c, int cl, int st, int go, int si);
      cfg = 3'(c);
      calcs = 10'(cl);
      stride = 10'(st);
      goff = 8'(go);
      sio = 8'(si);
      trg = 1'b1;
      mon();
      sb.delete();
      stalled = 0;
      gen(c, cl, st, go, si);
      adv();
      t0 = cyc_n;
      trg = 1'b0;
      cfg = 3'd7;
      calcs = 10'h3ff;
      stride = 10'h155;
      goff = 8'haa;
      sio = 8'h55;
   endtask

   task automatic drain(int lat);
      int n = 0;
      while (sb.size() > 0 && n < 2000) begin
         mon();
         adv();
         n++;
      end
      check("drain_empty", sb.size(), 0);
      check("done_pulse", done, 1);
      check("valid_drop", valid, 0);
      check("busy_drop", busy, 0);
      if (lat > 0) check("done_latency", cyc_n - t0, lat);
      mon();
      adv();
      check("done_one_cycle", done, 0);
   endtask

   initial begin
      int d0;
      rst = 1'b1;
      cfg = '0;
      working = 1'b1;
      trg = 1'b0;
      calcs = '0;
      sio = '0;
      stride = '0;
      goff = '0;
      ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", valid, 0);
      check("rst_a", addr_a, 0);
      check("rst_b", addr_b, 0);
      check("rst_tw", tw, 0);
      check("rst_last", last, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      adv();

      trig(0, 1, 1, 1, 0);
      drain(32);
      trig(0, 32, 32, 32, 1);
      drain(32);
      trig(0, 2, 2, 2, 16);
      drain(32);
      trig(1, 4, 8, 8, 2);
      drain(64);
      trig(0, 0, 3, 1, 5);
      drain(32);

      bp = 1;
      bp_idx = 0;
      trig(0, 2, 2, 2, 16);
      drain(0);
      bp = 0;
      ready = 1'b1;

      d0 = done_cnt;
      trig(0, 1, 1, 1, 0);
      repeat (10) begin mon(); adv(); end
      check("abort_left", sb.size(), 22);
      trig(0, 1, 4, 4, 0);
      check("abort_a0", addr_a, 0);
      check("abort_b0", addr_b, 4);
      drain(32);
      check("abort_done_cnt", done_cnt - d0, 1);

      d0 = done_cnt;
      trig(0, 1, 1, 1, 0);
      repeat (31) begin mon(); adv(); end
      check("coinc_left", sb.size(), 1);
      trig(0, 32, 32, 32, 1);
      drain(32);
      check("coinc_done_cnt", done_cnt - d0, 1);

      d0 = done_cnt;
      trig(0, 2, 2, 2, 16);
      repeat (5) begin mon(); adv(); end
      rst = 1'b1;
      #1;
      check("mrst_valid", valid, 0);
      check("mrst_a", addr_a, 0);
      check("mrst_b", addr_b, 0);
      check("mrst_tw", tw, 0);
      check("mrst_last", last, 0);
      check("mrst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      stalled = 0;
      trig(0, 2, 2, 2, 16);
      drain(32);
      check("mrst_done_cnt", done_cnt - d0, 1);

      d0 = done_cnt;
      trig(0, 32, 32, 32, 1);
      repeat (5) begin mon(); adv(); end
      working = 1'b0;
      mon();
      adv();
      check("wdrop_valid", valid, 0);
      check("wdrop_busy", busy, 0);
      sb.delete();
      stalled = 0;
      trg = 1'b1;
      adv();
      trg = 1'b0;
      check("wlow_trig_ign", valid, 0);
      repeat (3) begin mon(); adv(); end
      check("wdrop_done_cnt", done_cnt - d0, 0);
      working = 1'b1;
      trig(0, 1, 1, 1, 0);
      drain(32);
      check("wdrop_done_cnt2", done_cnt - d0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ntt_addr_gen.md
# ntt_addr_gen

Butterfly address generator sitting directly downstream of `point_config`. On each new-stage trigger it latches the stage geometry (calcs per group, stride, stride index offset, group offset) and walks every butterfly of the stage. For each butterfly it emits an operand address pair and a twiddle index to the butterfly datapath through a valid/ready handshake. It pulses a stage-done flag after the last butterfly.

## Interface
Parameters:
- ADDR_W, 13, width of memory addresses (max N = 8192 points)
- TW_W, 12, width of twiddle index

Ports:
- clk  in  1  system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_point_configuration  in  3  N = 64 << cfg (64..8192)
- i_working  in  1  transform active; low forces idle
- i_new_stage_trigger  in  1  one-cycle pulse from point_config, start of stage
- i_calcs_per_group  in  10  butterflies per group
- i_stride_index_offset  in  8  twiddle increment per butterfly within a group
- i_stride  in  10  distance between operand A and operand B
- i_group_offset  in  8  extra base advance between groups, added to stride
- i_ready  in  1  datapath accepts current pair
- o_valid  out  1  address pair/twiddle valid
- o_addr_a  out  ADDR_W  operand A address
- o_addr_b  out  ADDR_W  operand B address
- o_twiddle_idx  out  TW_W  twiddle index
- o_last  out  1  current pair is final butterfly of stage
- o_stage_done  out  1  one-cycle pulse after final pair accepted
- o_busy  out  1  high in RUN

## Operation
- Clock is `clk`. Reset is asynchronous and active-high, named `i_reset`.
- FSM states IDLE and RUN.
  - IDLE -> RUN on `i_new_stage_trigger && i_working`.
  - RUN -> IDLE after the final pair handshake, or when `i_working` is low.
- Latch on trigger: cfg, calcs (0 treated as 1), stride, stride_index_offset, group_offset. Total butterflies T = 32 << cfg (12-bit counter).
- Trigger clears the counters: k (index in group) = 0, group_base = 0, tw = 0, count = 0.
- Outputs:
  - addr_a = group_base + k
  - addr_b = addr_a + stride
  - twiddle = tw
  - all truncated mod 2^ADDR_W / 2^TW_W
- On each handshake (`o_valid && i_ready`):
  - count += 1.
  - If k == calcs-1: k = 0, tw = 0, group_base += stride + group_offset.
  - Otherwise: k += 1, tw += stride_index_offset.
- `o_last` = (count == T-1) while valid.
- After the handshake on the last pair:
  - `o_valid` drops next cycle.
  - `o_stage_done` pulses high for exactly one cycle.
  - FSM returns to IDLE.
- Trigger while in RUN: abort current stage, relatch geometry, restart counters. No `o_stage_done` is issued for the aborted stage.
- Trigger while `i_working` is low is ignored.
- `i_working` low in RUN: go to IDLE next edge, `o_valid` low, no done pulse.
- Geometry inputs are ignored except on the trigger edge.

## Timing
- Reset values: `o_valid` 0, `o_addr_a` 0, `o_addr_b` 0, `o_twiddle_idx` 0, `o_last` 0, `o_stage_done` 0, `o_busy` 0, FSM IDLE.
- All outputs are registered.
- Trigger sampled at edge t: `o_valid`/`o_busy` high after edge t, first pair (0, stride) presented.
- With `i_ready` held high: one pair per cycle. Stage of T butterflies occupies cycles t..t+T-1. `o_stage_done` is high in cycle t+T.
- `i_ready` low: outputs hold stable, counters frozen. `o_valid` never drops without a handshake except on abort or `i_working` low.
- Trigger coincident with the final handshake: the restart wins and no done pulse is issued.
- Reset mid-RUN: all outputs return to reset values immediately (asynchronous).

## Test plan
- cfg=0, calcs=1, stride=1, offset=1, sio=0, ready=1 -> pairs (0,1),(2,3)…(62,63), twiddle 0, o_last on 32nd pair, done pulse 32 cycles after trigger.
- cfg=0, calcs=32, stride=32, offset=32, sio=1 -> pairs (k,k+32) for k=0..31, twiddle = k, single group, done pulse.
- cfg=0, calcs=2, stride=2, offset=2, sio=16 -> (0,2,0),(1,3,16),(4,6,0),(5,7,16)…(61,63,16).
- Backpressure: ready toggled 1,0,0,1 mid-stage -> outputs stable while ready=0. Total handshakes still 32, no pair skipped or repeated.
- Abort: second trigger after 10 pairs with new stride=4 -> restart at (0,4), counters cleared, no done for first stage.
- Reset pulse at pair 5 and i_working drop at pair 5 (separate runs) -> o_valid low. Reset zeroes outputs asynchronously; next trigger starts cleanly at pair 0.
